mem_stage_sram_ctrl: RTL and testbench

Memory-stage controller between EXE2MEM and MEM2WB. Takes the ALU result as a byte address and the MEM_R_EN/MEM_W_EN controls. Runs each 32-bit load or store as two 16-bit accesses to an external SRAM with fixed wait states. Drives `ready` low while an access is in flight so the hazard/freeze logic stalls the pipeline, and presents the assembled load word as memReadVal for MEM2WB.

---
 rtl/mem_stage_sram_ctrl_pkg.sv | 19 +
 rtl/mem_stage_sram_ctrl_phase_counter.sv | 30 +++
 rtl/mem_stage_sram_ctrl.sv | 110 +++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared widths, base address and FSM encoding for the memory-stage SRAM controller.
package mem_stage_sram_ctrl_pkg;
  localparam int WORD_LEN      = 32;
  localparam int SRAM_ADDR_LEN = 18;
  localparam int SRAM_DATA_LEN = 16;
  localparam int DATA_MEM_BASE = 1024;

  typedef enum logic [1:0] {
    MEMS_IDLE = 2'd0,
    MEMS_LOW  = 2'd1,
    MEMS_HIGH = 2'd2,
    MEMS_DONE = 2'd3
  } mems_state_e;

  // A single-cycle phase still needs a one-bit counter.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  endfunction
endpackage

// File: rtl/mem_stage_sram_ctrl_phase_counter.sv
// Wait-state counter for one 16-bit SRAM phase; tc_o marks the last held cycle.
module sram_phase_counter
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage: splits each 32-bit load/store into low/high 16-bit SRAM phases and
// holds ready low until the access completes.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = DATA_MEM_BASE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MEM_R_EN,
  input  logic                     MEM_W_EN,
  input  logic [WORD_LEN-1:0]      ALURes,
  input  logic [WORD_LEN-1:0]      STVal,
  output logic [WORD_LEN-1:0]      memReadVal,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
  output logic [SRAM_DATA_LEN-1:0] SRAM_WDATA,
  input  logic [SRAM_DATA_LEN-1:0] SRAM_RDATA,
  output logic                     SRAM_WE_EN,
  output logic                     SRAM_RD_EN,
  output logic [1:0]               debug_state_o
);
  mems_state_e state_q, state_d;

  logic                     req;
  logic                     tc;
  logic                     in_phase;
  logic                     wr_q;
  logic [SRAM_ADDR_LEN-2:0] idx_q, idx_d;
  logic [WORD_LEN-1:0]      st_q;
  logic [SRAM_DATA_LEN-1:0] lowbuf_q;
  logic [WORD_LEN-1:0]      rdval_q;

  assign req      = MEM_R_EN | MEM_W_EN;
  assign in_phase = (state_q == MEMS_LOW) || (state_q == MEMS_HIGH);
  // Out-of-range addresses wrap silently by truncating the word index.
  assign idx_d    = (SRAM_ADDR_LEN-1)'((ALURes - WORD_LEN'(BASE_ADDR)) >> 2);

  sram_phase_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_phase_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tc || !in_phase),
    .en_i  (in_phase),
    .tc_o  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MEMS_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEMS_IDLE: if (req) state_d = MEMS_LOW;
      MEMS_LOW:  if (tc)  state_d = MEMS_HIGH;
      MEMS_HIGH: if (tc)  state_d = MEMS_DONE;
      MEMS_DONE:          state_d = MEMS_IDLE;
      default:            state_d = MEMS_IDLE;
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    SRAM_ADDR  = '0;
    SRAM_WDATA = '0;
    SRAM_WE_EN = 1'b0;
    SRAM_RD_EN = 1'b0;
    case (state_q)
      MEMS_IDLE: ready = !req;
      MEMS_LOW: begin
        SRAM_ADDR  = {idx_q, 1'b0};
        SRAM_WDATA = wr_q ? st_q[15:0] : '0;
        SRAM_WE_EN = wr_q;
        SRAM_RD_EN = !wr_q;
      end
      MEMS_HIGH: begin
        SRAM_ADDR  = {idx_q, 1'b1};
        SRAM_WDATA = wr_q ? st_q[31:16] : '0;
        SRAM_WE_EN = wr_q;
        SRAM_RD_EN = !wr_q;
      end
      MEMS_DONE: ready = 1'b1;
      default:   ready = 1'b0;
    endcase
  end

  // Request fields are captured once; the pipeline inputs are ignored until DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= 1'b0;
      idx_q    <= '0;
      st_q     <= '0;
      lowbuf_q <= '0;
      rdval_q  <= '0;
    end else begin
      if (state_q == MEMS_IDLE && req) begin
        wr_q  <= MEM_W_EN;
        idx_q <= idx_d;
        st_q  <= STVal;
      end
      if (state_q == MEMS_LOW && tc && !wr_q)  lowbuf_q <= SRAM_RDATA;
      if (state_q == MEMS_HIGH && tc && !wr_q) rdval_q  <= {SRAM_RDATA, lowbuf_q};
    end
  end

  assign memReadVal    = rdval_q;
  assign debug_state_o = state_q;
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench: two controller instances (W=2 and W=1) against a behavioural SRAM, with a
// strobe/completion scoreboard checked by a single negedge monitor.
module tb_mem_stage_sram_ctrl;
  import mem_stage_sram_ctrl_pkg::*;

  // Valid/ready: a request (MEM_R_EN|MEM_W_EN) is held until the negedge where ready
  // is seen high with it; the enables are dropped #1 after the following posedge.
  logic        clk, rst;
  logic [1:0]  r_en, w_en, ready, we, rd;
  logic [31:0] alu [2];
  logic [31:0] stv [2];
  logic [31:0] mrv [2];
  logic [17:0] saddr [2];
  logic [15:0] wdata [2];
  logic [15:0] rdata [2];
  logic [1:0]  dbg [2];

  logic [36:0] strobe_exp_q[$];
  logic [40:0] done_exp_q[$];

  int          n_tests, n_fail, drv_tmo;
  int          stall [2];
  logic [31:0] exp_mrv [2];
  logic [36:0] se;
  logic [40:0] de;
  logic        end_req, end_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : 1;
    logic [15:0] sram [0:255];

    mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(1024)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .MEM_R_EN      (r_en[g]),
      .MEM_W_EN      (w_en[g]),
      .ALURes        (alu[g]),
      .STVal         (stv[g]),
      .memReadVal    (mrv[g]),
      .ready         (ready[g]),
      .SRAM_ADDR     (saddr[g]),
      .SRAM_WDATA    (wdata[g]),
      .SRAM_RDATA    (rdata[g]),
      .SRAM_WE_EN    (we[g]),
      .SRAM_RD_EN    (rd[g]),
      .debug_state_o (dbg[g])
    );

    always @(posedge clk) if (we[g]) sram[saddr[g][7:0]] <= wdata[g];
    assign rdata[g] = sram[saddr[g][7:0]];
  end

  task automatic check(input string nm, input int g, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d got=%h exp=%h @%0t", nm, g, got, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        stall[g]   = 0;
        exp_mrv[g] = 32'h0;
        check("rst_ready", g, 32'(ready[g]), 32'h1);
        check("rst_strobes", g, {30'h0, we[g], rd[g]}, 32'h0);
        check("rst_addr", g, 32'(saddr[g]), 32'h0);
        check("rst_wdata", g, 32'(wdata[g]), 32'h0);
        check("rst_memreadval", g, mrv[g], 32'h0);
      end else begin
        if (we[g] || rd[g]) begin
          if (strobe_exp_q.size() == 0) begin
            check("strobe_unexpected", g, {30'h0, we[g], rd[g]}, 32'h0);
          end else begin
            se = strobe_exp_q.pop_front();
            check("strobe_dut", g, 32'(g), 32'(se[36]));
            check("strobe_we_rd", g, {30'h0, we[g], rd[g]}, {30'h0, se[35], se[34]});
            check("strobe_addr", g, 32'(saddr[g]), 32'(se[33:16]));
            if (se[35]) check("strobe_wdata", g, 32'(wdata[g]), 32'(se[15:0]));
          end
        end
        if (dbg[g] == MEMS_IDLE && !(r_en[g] || w_en[g])) begin
          check("idle_ready", g, 32'(ready[g]), 32'h1);
          check("idle_addr", g, 32'(saddr[g]), 32'h0);
          check("idle_memreadval", g, mrv[g], exp_mrv[g]);
        end
        if (!(r_en[g] || w_en[g])) begin
          stall[g] = 0;
        end else if (!ready[g]) begin
          stall[g]++;
        end else if (stall[g] > 0) begin
          if (done_exp_q.size() == 0) begin
            check("done_unexpected", g, 32'(stall[g]), 32'h0);
          end else begin
            de = done_exp_q.pop_front();
            check("done_dut", g, 32'(g), 32'(de[40]));
            check("stall_cycles", g, 32'(stall[g]), 32'(de[39:32]));
            check("memreadval", g, mrv[g], de[31:0]);
            exp_mrv[g] = de[31:0];
          end
          stall[g] = 0;
        end
      end
    end
    if (end_req && !end_done) begin
      check("strobe_q_empty", 0, 32'(strobe_exp_q.size()), 32'h0);
      check("done_q_empty", 0, 32'(done_exp_q.size()), 32'h0);
      check("driver_timeouts", 0, 32'(drv_tmo), 32'h0);
      end_done = 1'b1;
    end
  end

  task automatic push_strobes(input int g, input int w, input logic wr, input logic [17:0] ha,
                              input logic [31:0] st, input int phases);
    for (int p = 0; p < phases; p++)
      for (int c = 0; c < w; c++)
        strobe_exp_q.push_back({g[0], wr, ~wr, ha[17:1], p[0], (p == 0) ? st[15:0] : st[31:16]});
  endtask

  // One full access: ha = hand-computed low halfword address, stl = expected stall length.
  task automatic access(input int g, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] st, input logic [17:0] ha, input int stl,
                        input logic [31:0] exp_val);
    int n;
    push_strobes(g, (g == 0) ? 2 : 1, w, ha, st, 2);
    done_exp_q.push_back({g[0], 8'(stl), exp_val});
    r_en[g] = r;
    w_en[g] = w;
    alu[g]  = a;
    stv[g]  = st;
    @(posedge clk);
    #1;
    alu[g] = $urandom();
    stv[g] = $urandom();
    n = 0;
    while (1) begin
      @(negedge clk);
      if (ready[g]) break;
      n++;
      if (n > 50) begin
        drv_tmo++;
        $display("FAIL access_timeout dut%0d addr=%0d got no ready exp ready within 50 cycles", g, a);
        break;
      end
    end
    @(posedge clk);
    #1;
    r_en[g] = 1'b0;
    w_en[g] = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; drv_tmo = 0;
    end_req = 1'b0; end_done = 1'b0;
    rst = 1'b1;
    r_en = '0; w_en = '0;
    for (int g = 0; g < 2; g++) begin
      alu[g] = '0; stv[g] = '0; stall[g] = 0; exp_mrv[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // W = 2
    access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2, 5, 32'h0);
    access(0, 1'b1, 1'b0, 32'd1028, 32'h0,        18'd2, 5, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #1;
    access(0, 1'b1, 1'b1, 32'd1024, 32'h12345678, 18'd0, 5, 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 18'h3FFFE, 5, 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 32'd1020, 32'h0,        18'h3FFFE, 5, 32'hCAFEF00D);
    access(0, 1'b1, 1'b0, 32'd1024, 32'h0,        18'd0, 5, 32'h12345678);

    // Reset during the second HIGH cycle of a load
    push_strobes(0, 2, 1'b0, 18'd2, 32'h0, 1);
    strobe_exp_q.push_back({1'b0, 1'b0, 1'b1, 18'd3, 16'h0});
    r_en[0] = 1'b1;
    alu[0]  = 32'd1028;
    repeat (4) @(posedge clk);
    #1;
    rst     = 1'b1;
    r_en[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    access(0, 1'b1, 1'b0, 32'd1028, 32'h0, 18'd2, 5, 32'hDEADBEEF);

    // W = 1, stores then back-to-back loads
    access(1, 1'b0, 1'b1, 32'd1024, 32'h11112222, 18'd0, 3, 32'h0);
    access(1, 1'b0, 1'b1, 32'd1032, 32'h33334444, 18'd4, 3, 32'h0);
    access(1, 1'b1, 1'b0, 32'd1024, 32'h0,        18'd0, 3, 32'h11112222);
    access(1, 1'b1, 1'b0, 32'd1032, 32'h0,        18'd4, 3, 32'h33334444);
    repeat (3) @(posedge clk);
    #1;

    end_req = 1'b1;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
